// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types, constants and helpers for the fetch PC generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2
    } fetch_state_e;

    localparam logic [63:0] c_DEFAULT_RESET_PC = 64'h0;

    // Mask that clears the sub-instruction address bits; 2-byte steps keep bit 1.
    function automatic logic [63:0] align_mask(input int inst_bytes);
        return (inst_bytes == 2) ? ~64'd1 : ~64'd3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stat_cnt.sv
// ============================================================================
// Module      : fetch_stat_cnt
// Description : CNT_W-bit wrapping statistics counter with enable and sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
// ============================================================================
// Module      : fetch_pc_gen
// Description : Fetch address generator with reset vector, stall, redirect and
//               statistics counters. Optional misaligned-redirect reporting is
//               enabled by defining FETCH_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(c_DEFAULT_RESET_PC),
    parameter int              INST_BYTES = 4,
    parameter int              CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_v,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  pc_p,
    output logic [XLEN-1:0]  pc_i,
    output logic             inst_v_i,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] redir_cnt,
    output logic             fetch_err,
    output logic [XLEN-1:0]  err_pc
);

    localparam logic [63:0]     c_MASK64 = align_mask(INST_BYTES);
    localparam logic [XLEN-1:0] c_MASK   = c_MASK64[XLEN-1:0];
    localparam logic [XLEN-1:0] c_INC    = XLEN'(INST_BYTES);

    fetch_state_e    r_state;
    fetch_state_e    w_state;
    logic [XLEN-1:0] r_pc_i;
    logic            r_inst_v;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_redir_aligned;
    logic            w_run;
    logic            w_accept;
    logic            w_redir_take;

    // The registered state already reads BOOT in the first cycle after reset
    // drops, so that cycle forces the boot address and the next one is RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign w_state         = reset ? ST_RESET : r_state;
    assign w_run           = (w_state == ST_RUN);
    assign w_redir_aligned = redirect_pc & c_MASK;
    assign w_accept        = w_run && r_inst_v && !stall;
    assign w_redir_take    = w_run && redirect_v;

    always_comb begin
        w_pc_next = r_pc_i + c_INC;
        if (!w_run) begin
            w_pc_next = RESET_PC;
        end else if (redirect_v) begin
            w_pc_next = w_redir_aligned;
        end else if (stall && r_inst_v) begin
            w_pc_next = r_pc_i;
        end
    end

    always_ff @(posedge clk) begin
        r_pc_i   <= w_pc_next;
        r_inst_v <= !reset;
    end

    assign pc_p     = w_pc_next;
    assign pc_i     = r_pc_i;
    assign inst_v_i = r_inst_v;

    fetch_stat_cnt #(
        .CNT_W (CNT_W)
    ) u_fetch_cnt (
        .clk   (clk),
        .i_clr (reset),
        .i_inc (w_accept),
        .o_cnt (fetch_cnt)
    );

    fetch_stat_cnt #(
        .CNT_W (CNT_W)
    ) u_redir_cnt (
        .clk   (clk),
        .i_clr (reset),
        .i_inc (w_redir_take),
        .o_cnt (redir_cnt)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic            r_fetch_err;
    logic [XLEN-1:0] r_err_pc;
    logic            w_misalign;

    assign w_misalign = w_redir_take && (redirect_pc != w_redir_aligned);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_err <= 1'b0;
            r_err_pc    <= '0;
        end else begin
            r_fetch_err <= w_misalign;
            if (w_misalign) begin
                r_err_pc <= redirect_pc;
            end
        end
    end

    assign fetch_err = r_fetch_err;
    assign err_pc    = r_err_pc;
`else
    assign fetch_err = 1'b0;
    assign err_pc    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
// ============================================================================
// Module      : tb_fetch_pc_gen
// Description : Directed self-checking bench for fetch_pc_gen (RESET_PC=0x100,
//               CNT_W=4); expectations follow FETCH_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_gen;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             redirect_v;
    logic [XLEN-1:0]  redirect_pc;
    logic [XLEN-1:0]  pc_p;
    logic [XLEN-1:0]  pc_i;
    logic             inst_v_i;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] redir_cnt;
    logic             fetch_err;
    logic [XLEN-1:0]  err_pc;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic        c_ERR_EN   = 1'b1;
    localparam logic [31:0] c_ERR_PC_2 = 32'h0000_2002;
`else
    localparam logic        c_ERR_EN   = 1'b0;
    localparam logic [31:0] c_ERR_PC_2 = 32'h0;
`endif

    fetch_pc_gen #(
        .XLEN       (XLEN),
        .RESET_PC   (32'h0000_0100),
        .INST_BYTES (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect_v  (redirect_v),
        .redirect_pc (redirect_pc),
        .pc_p        (pc_p),
        .pc_i        (pc_i),
        .inst_v_i    (inst_v_i),
        .fetch_cnt   (fetch_cnt),
        .redir_cnt   (redir_cnt),
        .fetch_err   (fetch_err),
        .err_pc      (err_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_v,
                             input logic [31:0] e_fc, input logic [31:0] e_rc);
        chk({tag, ".pc_i"}, pc_i, e_pc);
        chk({tag, ".inst_v"}, 32'(inst_v_i), 32'(e_v));
        chk({tag, ".fetch_cnt"}, 32'(fetch_cnt), e_fc);
        chk({tag, ".redir_cnt"}, 32'(redir_cnt), e_rc);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect_v  = 1'b0;
        redirect_pc = '0;
        repeat (3) tick();

        chk_state("rst", 32'h100, 1'b0, 0, 0);
        chk("rst.pc_p", pc_p, 32'h100);
        chk("rst.fetch_err", 32'(fetch_err), 32'h0);
        chk("rst.err_pc", err_pc, 32'h0);

        // Boot sequence
        reset = 1'b0;
        tick();
        chk_state("c0", 32'h100, 1'b1, 0, 0);
        tick();
        chk_state("c1", 32'h104, 1'b1, 1, 0);
        tick();
        chk_state("c2", 32'h108, 1'b1, 2, 0);

        // Two stall cycles at 0x108
        stall = 1'b1;
        #1;
        chk("stall.pc_p", pc_p, 32'h108);
        tick();
        chk_state("stall1", 32'h108, 1'b1, 2, 0);
        chk("stall1.pc_p", pc_p, 32'h108);
        tick();
        chk_state("stall2", 32'h108, 1'b1, 2, 0);
        stall = 1'b0;
        #1;
        chk("unstall.pc_p", pc_p, 32'h10C);
        tick();
        chk_state("unstall", 32'h10C, 1'b1, 3, 0);

        // Redirect while stalled: redirect wins, stalled instruction not counted
        stall       = 1'b1;
        redirect_v  = 1'b1;
        redirect_pc = 32'h2000;
        #1;
        chk("rds.pc_p", pc_p, 32'h2000);
        tick();
        chk_state("rds", 32'h2000, 1'b1, 3, 1);
        chk("rds.fetch_err", 32'(fetch_err), 32'h0);

        // Misaligned redirect
        stall       = 1'b0;
        redirect_pc = 32'h2002;
        #1;
        chk("mis.pc_p", pc_p, 32'h2000);
        tick();
        redirect_v = 1'b0;
        chk_state("mis", 32'h2000, 1'b1, 4, 2);
        chk("mis.fetch_err", 32'(fetch_err), 32'(c_ERR_EN));
        chk("mis.err_pc", err_pc, c_ERR_PC_2);
        tick();
        chk_state("mis2", 32'h2004, 1'b1, 5, 2);
        chk("mis2.fetch_err", 32'(fetch_err), 32'h0);
        chk("mis2.err_pc", err_pc, c_ERR_PC_2);

        // Address wrap at the top of the space
        redirect_v  = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_v = 1'b0;
        chk_state("top", 32'hFFFF_FFFC, 1'b1, 6, 3);
        tick();
        chk_state("wrap", 32'h0, 1'b1, 7, 3);

        // Reset with a redirect pending: redirect ignored, everything clears
        reset       = 1'b1;
        redirect_v  = 1'b1;
        redirect_pc = 32'h3000;
        #1;
        chk("rr.pc_p", pc_p, 32'h100);
        tick();
        chk_state("rr", 32'h100, 1'b0, 0, 0);
        chk("rr.fetch_err", 32'(fetch_err), 32'h0);
        chk("rr.err_pc", err_pc, 32'h0);

        // Redirect in the boot cycle is also ignored
        reset = 1'b0;
        #1;
        chk("boot.pc_p", pc_p, 32'h100);
        tick();
        redirect_v = 1'b0;
        chk_state("boot", 32'h100, 1'b1, 0, 0);

        // 17 accepts on a 4-bit counter wraps to 1
        repeat (16) tick();
        chk_state("acc16", 32'h140, 1'b1, 0, 0);
        tick();
        chk_state("acc17", 32'h144, 1'b1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
